// File: rtl/ysyx_220066_mem_pkg.sv
// ============================================================================
// ysyx_220066_mem_pkg : shared types and address helpers for the data-port responder
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_220066_mem_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned MASK_W     = 8;
    localparam int unsigned WORD_SHIFT = 3;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // The upper bound is computed one bit wider so a window ending at 2^64 cannot wrap.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] base,
                                           input int unsigned     depth_words);
        logic [XLEN:0] limit;
        limit = {1'b0, base} + ({33'b0, depth_words} << WORD_SHIFT);
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_220066_mem_responder_if.sv
// ============================================================================
// ysyx_220066_mem_responder_if : request/response bundle between core and responder
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_220066_mem_responder_if;
    import ysyx_220066_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

`default_nettype wire

// File: rtl/ysyx_220066_sram_1rw.sv
// ============================================================================
// ysyx_220066_sram_1rw : single-port byte-masked word array with registered read data
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_220066_sram_1rw
    import ysyx_220066_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  wire logic                           clk,
    input  wire logic                           en_i,
    input  wire logic                           we_i,
    input  wire logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  wire logic [XLEN-1:0]                wdata_i,
    input  wire logic [MASK_W-1:0]              wmask_i,
    output logic [XLEN-1:0]                     rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    // Read data captures the pre-write contents; the responder discards it on writes.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (wmask_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_220066_mem_responder.sv
// ============================================================================
// ysyx_220066_mem_responder : wait-state data-port slave backed by internal storage
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_220066_mem_responder
    import ysyx_220066_mem_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] ADDR_BASE   = 64'h8000_0000,
    parameter int unsigned     LATENCY     = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    ysyx_220066_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              rd_ok_q, rd_ok_d;
    logic              err_q, err_d;

    logic              access;
    logic              in_range;
    logic [XLEN-1:0]   offset;
    logic [IDX_W-1:0]  idx;
    logic [XLEN-1:0]   sram_rdata;

    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    assign in_range = addr_in_range(addr_q, ADDR_BASE, DEPTH_WORDS);
    assign offset   = addr_q - ADDR_BASE;
    assign idx      = IDX_W'(offset >> WORD_SHIFT);

    // Gating with rst keeps a write from committing on a reset edge.
    ysyx_220066_sram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk     (clk),
        .en_i    (access && in_range && rst),
        .we_i    (wr_q),
        .idx_i   (idx),
        .wdata_i (wdata_q),
        .wmask_i (wmask_q),
        .rdata_o (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rd_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rd_ok_q <= rd_ok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rd_ok_d = rd_ok_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    addr_d  = bus.req_addr & ~64'h7;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rd_ok_d = in_range && !wr_q;
                    err_d   = !in_range;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    rd_ok_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data lives in the array's output register; rd_ok_q zeroes it for writes and errors.
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rd_ok_q ? sram_rdata : '0;
    assign bus.resp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_220066_mem_responder.sv
// ============================================================================
// tb_ysyx_220066_mem_responder : scoreboard bench with a word-array reference model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_220066_mem_responder;
    import ysyx_220066_mem_pkg::*;

    localparam int unsigned     DEPTH = 1024;
    localparam logic [63:0]     BASE  = 64'h8000_0000;
    localparam int unsigned     LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_220066_mem_responder_if bus();

    logic        req_valid = 1'b0;
    logic        req_wr    = 1'b0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        resp_ready = 1'b1;

    assign bus.req_valid  = req_valid;
    assign bus.req_wr     = req_wr;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.req_wmask  = req_wmask;
    assign bus.resp_ready = resp_ready;

    ysyx_220066_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_BASE   (BASE),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model[int];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    logic        rand_ready  = 1'b0;
    logic        force_ready = 1'b1;
    logic        prev_v      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        resp_ready <= rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endfunction

    // Monitor: every cycle a response is shown it must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && bus.resp_valid) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected_resp");
            end else begin
                if (!prev_v) check("resp_latency", 64'(cyc), 64'(sb_q[0].cyc));
                check("resp_rdata", bus.resp_rdata, sb_q[0].rdata);
                check("resp_err", 64'(bus.resp_err), 64'(sb_q[0].err));
                check("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
                if (resp_ready) void'(sb_q.pop_front());
            end
        end
        prev_v <= rst && bus.resp_valid;
    end

    // Called at a negedge with the request already driven; returns at a negedge.
    task automatic accept_cur();
        int          n;
        exp_t        e;
        logic [63:0] a;
        logic [63:0] w;
        int          idx;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        a     = req_addr & ~64'h7;
        e.cyc = cyc + LAT + 2;
        if (a >= BASE && a < BASE + 64'(8 * DEPTH)) begin
            idx   = int'((a - BASE) / 8);
            e.err = 1'b0;
            if (req_wr) begin
                w = model.exists(idx) ? model[idx] : 64'd0;
                for (int b = 0; b < 8; b++)
                    if (req_wmask[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                model[idx] = w;
                e.rdata    = 64'd0;
            end else begin
                e.rdata = model[idx];
            end
        end else begin
            e.rdata = 64'd0;
            e.err   = 1'b1;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive(input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask);
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = mask;
        req_valid = 1'b1;
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask);
        drive(wr, addr, wdata, mask);
        accept_cur();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.resp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || bus.resp_valid) fail_now("idle_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          sel;
        logic [63:0] addr;
        logic [7:0]  mask;

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 64'(bus.req_ready), 64'd1);
        check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("reset_resp_err", 64'(bus.resp_err), 64'd0);
        check("reset_resp_rdata", bus.resp_rdata, 64'd0);

        for (int i = 0; i < 16; i++)
            issue(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
        issue(1'b1, BASE + 64'(8 * 1023), {$urandom, $urandom}, 8'hFF);

        issue(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
        issue(1'b0, 64'h8000_0013, 64'd0, 8'h00);
        issue(1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h30);
        issue(1'b0, 64'h8000_0010, 64'd0, 8'h00);
        issue(1'b1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        issue(1'b0, 64'h8000_0018, 64'd0, 8'h00);

        issue(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00);
        issue(1'b0, 64'h8000_2000, 64'd0, 8'h00);
        issue(1'b1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        issue(1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        issue(1'b0, BASE, 64'd0, 8'h00);
        issue(1'b0, 64'h8000_1FFF, 64'd0, 8'h00);

        // Backpressure with a second request held pending.
        wait_idle();
        force_ready = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b0, 64'h8000_0010, 64'd0, 8'h00);
        drive(1'b1, 64'h8000_0020, 64'h0102_0304_0506_0708, 8'h0F);
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) fail_now("bp_resp_timeout");
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
            check("bp_resp_valid_held", 64'(bus.resp_valid), 64'd1);
        end
        force_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_req_ready", 64'(bus.req_ready), 64'd0);
        check("bp_hs_resp_valid", 64'(bus.resp_valid), 64'd1);
        @(negedge clk);
        check("bp_idle_req_ready", 64'(bus.req_ready), 64'd1);
        check("bp_idle_resp_valid", 64'(bus.resp_valid), 64'd0);
        accept_cur();
        issue(1'b0, 64'h8000_0020, 64'd0, 8'h00);

        // Reset while the write is waiting: it must vanish without a response.
        wait_idle();
        drive(1'b1, 64'h8000_0028, 64'h5555_5555_5555_5555, 8'hFF);
        while (!bus.req_ready) @(negedge clk);
        @(posedge clk);
        #1 begin
            req_valid = 1'b0;
            rst       = 1'b0;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (LAT + 4) begin
            @(negedge clk);
            check("dropped_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        check("after_rst_req_ready", 64'(bus.req_ready), 64'd1);
        issue(1'b0, 64'h8000_0028, 64'd0, 8'h00);

        // Randomized traffic with random response backpressure.
        wait_idle();
        rand_ready = 1'b1;
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = int'($urandom_range(0, 19));
            if (sel == 0)
                addr = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
            else if (sel == 1)
                addr = BASE + 64'(8 * DEPTH) + 64'($urandom_range(0, 63));
            else if (sel == 2)
                addr = BASE + 64'(8 * 1023) + 64'($urandom_range(0, 7));
            else
                addr = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            issue(1'($urandom), addr, {$urandom, $urandom}, mask);
        end
        for (int i = 0; i < 16; i++)
            issue(1'b0, BASE + 64'(8 * i), 64'd0, 8'h00);
        wait_idle();
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
